// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage LEGv8 pipeline.
// Detects load-use stalls, taken-branch flushes and data-RAM wait freezes,
// and selects the EX-stage forwarding sources. It keeps a shadow copy of the
// destination/control fields carried in ID/EX, EX/MEM and MEM/WB.
module hazard_ctrl #(
   parameter int REG_W    = 5,
   parameter int ZERO_REG = 31,
   parameter int CNT_W    = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rn,
   input  logic [REG_W-1:0] id_rm,
   input  logic             id_uses_rn,
   input  logic             id_uses_rm,
   input  logic [REG_W-1:0] id_rd,
   input  logic             id_regwrite,
   input  logic             id_memread,
   input  logic             ex_branch_tkn,
   input  logic             mem_busy,
   output logic             pc_we,
   output logic             if_id_we,
   output logic             if_id_flush,
   output logic             id_ex_bubble,
   output logic             pipe_we,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [REG_W-1:0] ZR      = REG_W'(ZERO_REG);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_e;

   state_e           state_q, state_d;
   logic [REG_W-1:0] ex_rn_q, ex_rm_q, ex_rd_q, mem_rd_q, wb_rd_q;
   logic             ex_uses_rn_q, ex_uses_rm_q, ex_rw_q, ex_mr_q;
   logic             mem_rw_q, wb_rw_q;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
   logic             load_use, stall_inc, flush_inc, ex_load;

   // Forwarding select for one ALU operand; EX/MEM result is newer than MEM/WB.
   function automatic logic [1:0] fwd_sel(input logic uses, input logic [REG_W-1:0] src,
                                          input logic m_rw, input logic [REG_W-1:0] m_rd,
                                          input logic w_rw, input logic [REG_W-1:0] w_rd);
      logic [1:0] sel;
      sel = 2'b00;
      if (uses && src != ZR) begin
         if (m_rw && m_rd == src)      sel = 2'b10;
         else if (w_rw && w_rd == src) sel = 2'b01;
      end
      return sel;
   endfunction

   // A load in EX whose destination the ID instruction reads. In LU_STALL the
   // load has moved to MEM and EX holds the bubble, so detection is masked.
   assign load_use = (state_q != LU_STALL) && ex_mr_q && (ex_rd_q != ZR) &&
                     ((id_uses_rn && id_rn == ex_rd_q) || (id_uses_rm && id_rm == ex_rd_q));

   // Next state, pipeline enables, forwarding selects and counter increments.
   always_comb begin
      // NOTE: every output gets a default first so no path through the
      // if/else chain can leave it unassigned and infer a latch.
      state_d      = RUN;
      pc_we        = 1'b1;
      if_id_we     = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      pipe_we      = 1'b1;
      fwd_a        = 2'b00;
      fwd_b        = 2'b00;
      stall_inc    = 1'b0;
      flush_inc    = 1'b0;
      if (!reset) begin
         fwd_a = fwd_sel(ex_uses_rn_q, ex_rn_q, mem_rw_q, mem_rd_q, wb_rw_q, wb_rd_q);
         fwd_b = fwd_sel(ex_uses_rm_q, ex_rm_q, mem_rw_q, mem_rd_q, wb_rw_q, wb_rd_q);
         if (mem_busy) begin
            state_d   = MEM_WAIT;
            pc_we     = 1'b0;
            if_id_we  = 1'b0;
            pipe_we   = 1'b0;
            stall_inc = 1'b1;
         end else if (ex_branch_tkn) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            flush_inc    = 1'b1;
         end else if (load_use) begin
            state_d      = LU_STALL;
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            id_ex_bubble = 1'b1;
            stall_inc    = 1'b1;
         end
      end
   end

   assign ex_load     = id_valid && !id_ex_bubble;
   assign stall_cnt_d = (stall_inc && stall_cnt_q != CNT_MAX) ? stall_cnt_q + 1'b1 : stall_cnt_q;
   assign flush_cnt_d = (flush_inc && flush_cnt_q != CNT_MAX) ? flush_cnt_q + 1'b1 : flush_cnt_q;

   // State, counters and pipeline shadow registers.
   always_ff @(posedge clock) begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, matching the real pipeline registers shifting together.
      if (reset) begin
         state_q      <= RUN;
         stall_cnt_q  <= '0;
         flush_cnt_q  <= '0;
         ex_rn_q      <= '0;
         ex_rm_q      <= '0;
         ex_rd_q      <= '0;
         ex_uses_rn_q <= 1'b0;
         ex_uses_rm_q <= 1'b0;
         ex_rw_q      <= 1'b0;
         ex_mr_q      <= 1'b0;
         mem_rd_q     <= '0;
         mem_rw_q     <= 1'b0;
         wb_rd_q      <= '0;
         wb_rw_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         if (pipe_we) begin
            ex_rn_q      <= ex_load ? id_rn       : '0;
            ex_rm_q      <= ex_load ? id_rm       : '0;
            ex_rd_q      <= ex_load ? id_rd       : '0;
            ex_uses_rn_q <= ex_load ? id_uses_rn  : 1'b0;
            ex_uses_rm_q <= ex_load ? id_uses_rm  : 1'b0;
            ex_rw_q      <= ex_load ? id_regwrite : 1'b0;
            ex_mr_q      <= ex_load ? id_memread  : 1'b0;
            mem_rd_q     <= ex_rd_q;
            mem_rw_q     <= ex_rw_q;
            wb_rd_q      <= mem_rd_q;
            wb_rw_q      <= mem_rw_q;
         end
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: the stimulus process drives one ID
// instruction per cycle and queues the hand-computed response; a monitor
// pops and compares on every falling edge.
module tb_hazard_ctrl;

   localparam int REG_W = 5;
   localparam int CNT_W = 16;

   // {pc_we, if_id_we, if_id_flush, id_ex_bubble, pipe_we}
   localparam logic [4:0] C_RUN = 5'b11001;
   localparam logic [4:0] C_LU  = 5'b00011;
   localparam logic [4:0] C_BR  = 5'b11111;
   localparam logic [4:0] C_MW  = 5'b00000;

   logic             clock = 1'b0;
   logic             reset;
   logic             id_valid, id_uses_rn, id_uses_rm, id_regwrite, id_memread;
   logic [REG_W-1:0] id_rn, id_rm, id_rd;
   logic             ex_branch_tkn, mem_busy;
   logic             pc_we, if_id_we, if_id_flush, id_ex_bubble, pipe_we;
   logic [1:0]       fwd_a, fwd_b;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   typedef struct packed {
      logic       valid;
      logic [4:0] rn, rm;
      logic       urn, urm;
      logic [4:0] rd;
      logic       rw, mr;
   } instr_t;

   typedef struct packed {
      logic [4:0]  ctl;
      logic [1:0]  fa, fb;
      logic [15:0] sc, fc;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   int    checks = 0;
   int    errors = 0;

   hazard_ctrl #(.REG_W(REG_W), .ZERO_REG(31), .CNT_W(CNT_W)) dut (
      .clock(clock), .reset(reset), .id_valid(id_valid),
      .id_rn(id_rn), .id_rm(id_rm), .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
      .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
      .ex_branch_tkn(ex_branch_tkn), .mem_busy(mem_busy),
      .pc_we(pc_we), .if_id_we(if_id_we), .if_id_flush(if_id_flush),
      .id_ex_bubble(id_ex_bubble), .pipe_we(pipe_we),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clock = ~clock;

   function automatic instr_t nop();
      return '0;
   endfunction

   function automatic instr_t r_type(input int rd, input int rn, input int rm);
      instr_t i;
      i = '0;
      i.valid = 1'b1; i.rd = 5'(rd); i.rn = 5'(rn); i.rm = 5'(rm);
      i.urn = 1'b1; i.urm = 1'b1; i.rw = 1'b1;
      return i;
   endfunction

   function automatic instr_t ldur(input int rd, input int rn);
      instr_t i;
      i = '0;
      i.valid = 1'b1; i.rd = 5'(rd); i.rn = 5'(rn);
      i.urn = 1'b1; i.rw = 1'b1; i.mr = 1'b1;
      return i;
   endfunction

   function automatic instr_t cbz(input int rt);
      instr_t i;
      i = '0;
      i.valid = 1'b1; i.rm = 5'(rt); i.urm = 1'b1;
      return i;
   endfunction

   task automatic check(input string n, input string f, input logic [31:0] got,
                        input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s.%s got=%0h expected=%0h", n, f, got, want);
      end
   endtask

   // One stimulus cycle: drive inputs after the edge and queue the expected response.
   task automatic cyc(input string name, input logic rst, input instr_t ins,
                      input logic br, input logic busy, input logic [4:0] ctl,
                      input logic [1:0] fa, input logic [1:0] fb, input int sc, input int fc);
      exp_t e;
      @(posedge clock);
      #1;
      reset         = rst;
      id_valid      = ins.valid;
      id_rn         = ins.rn;
      id_rm         = ins.rm;
      id_uses_rn    = ins.urn;
      id_uses_rm    = ins.urm;
      id_rd         = ins.rd;
      id_regwrite   = ins.rw;
      id_memread    = ins.mr;
      ex_branch_tkn = br;
      mem_busy      = busy;
      e.ctl = ctl; e.fa = fa; e.fb = fb; e.sc = 16'(sc); e.fc = 16'(fc);
      exp_q.push_back(e);
      name_q.push_back(name);
   endtask

   // Monitor: the DUT presents a response every cycle; compare on the falling edge.
   initial begin
      exp_t  e;
      string n;
      forever begin
         @(negedge clock);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            check(n, "ctl", 32'({pc_we, if_id_we, if_id_flush, id_ex_bubble, pipe_we}), 32'(e.ctl));
            check(n, "fwd_a", 32'(fwd_a), 32'(e.fa));
            check(n, "fwd_b", 32'(fwd_b), 32'(e.fb));
            check(n, "stall_cnt", 32'(stall_cnt), 32'(e.sc));
            check(n, "flush_cnt", 32'(flush_cnt), 32'(e.fc));
         end
      end
   end

   initial begin
      instr_t inv;
      reset = 1'b1; id_valid = 1'b0; id_rn = '0; id_rm = '0; id_uses_rn = 1'b0;
      id_uses_rm = 1'b0; id_rd = '0; id_regwrite = 1'b0; id_memread = 1'b0;
      ex_branch_tkn = 1'b0; mem_busy = 1'b0;

      // reset state, enables forced even with mem_busy high
      cyc("rst0",     1, nop(),            0, 1, C_RUN, 2'b00, 2'b00, 0, 0);
      cyc("rst1",     1, r_type(1, 2, 3),  0, 0, C_RUN, 2'b00, 2'b00, 0, 0);
      // ADD X1 then SUB X2,X1,X3
      cyc("add_x1",   0, r_type(1, 2, 3),  0, 0, C_RUN, 2'b00, 2'b00, 0, 0);
      cyc("sub_id",   0, r_type(2, 1, 3),  0, 0, C_RUN, 2'b00, 2'b00, 0, 0);
      cyc("sub_ex",   0, nop(),            0, 0, C_RUN, 2'b10, 2'b00, 0, 0);
      // invalid ID slot carrying load fields must enter EX as a bubble
      inv = ldur(5, 5);
      inv.valid = 1'b0;
      cyc("invalid",  0, inv,              0, 0, C_RUN, 2'b00, 2'b00, 0, 0);
      // LDUR X4,[X5] then ADD X6,X4,X7
      cyc("ldur_x4",  0, ldur(4, 5),       0, 0, C_RUN, 2'b00, 2'b00, 0, 0);
      cyc("lu_stall", 0, r_type(6, 4, 7),  0, 0, C_LU,  2'b00, 2'b00, 0, 0);
      cyc("lu_after", 0, r_type(6, 4, 7),  0, 0, C_RUN, 2'b00, 2'b00, 1, 0);
      cyc("lu_fwd",   0, nop(),            0, 0, C_RUN, 2'b01, 2'b00, 1, 0);
      // taken branch with a simultaneous load-use: branch wins
      cyc("ldur_x9",  0, ldur(9, 5),       0, 0, C_RUN, 2'b00, 2'b00, 1, 0);
      cyc("br_vs_lu", 0, r_type(10, 9, 9), 1, 0, C_BR,  2'b00, 2'b00, 1, 0);
      cyc("br_after", 0, nop(),            0, 0, C_RUN, 2'b00, 2'b00, 1, 1);
      // mem_busy for 3 cycles while a taken CBZ sits in EX
      cyc("cbz_id",   0, cbz(3),           0, 0, C_RUN, 2'b00, 2'b00, 1, 1);
      cyc("mw1",      0, r_type(11,12,13), 1, 1, C_MW,  2'b00, 2'b00, 1, 1);
      cyc("mw2",      0, r_type(11,12,13), 1, 1, C_MW,  2'b00, 2'b00, 2, 1);
      cyc("mw3",      0, r_type(11,12,13), 1, 1, C_MW,  2'b00, 2'b00, 3, 1);
      cyc("mw_flush", 0, r_type(11,12,13), 1, 0, C_BR,  2'b00, 2'b00, 4, 1);
      cyc("mw_after", 0, nop(),            0, 0, C_RUN, 2'b00, 2'b00, 4, 2);
      // XZR is never a hazard or forwarding source
      cyc("add_x31",  0, r_type(31, 1, 2), 0, 0, C_RUN, 2'b00, 2'b00, 4, 2);
      cyc("use_x31",  0, r_type(8,31,31),  0, 0, C_RUN, 2'b00, 2'b00, 4, 2);
      cyc("ld_x31",   0, ldur(31, 5),      0, 0, C_RUN, 2'b00, 2'b00, 4, 2);
      cyc("ldu_x31",  0, r_type(14,31,31), 0, 0, C_RUN, 2'b00, 2'b00, 4, 2);
      cyc("x31_ex",   0, nop(),            0, 0, C_RUN, 2'b00, 2'b00, 4, 2);
      // EX/MEM beats MEM/WB; fwd_b paths
      cyc("p_add1a",  0, r_type(1, 2, 3),  0, 0, C_RUN, 2'b00, 2'b00, 4, 2);
      cyc("p_add1b",  0, r_type(1, 4, 5),  0, 0, C_RUN, 2'b00, 2'b00, 4, 2);
      cyc("p_sub7",   0, r_type(7, 6, 1),  0, 0, C_RUN, 2'b00, 2'b00, 4, 2);
      cyc("p_prio",   0, r_type(15, 1, 7), 0, 0, C_RUN, 2'b00, 2'b10, 4, 2);
      cyc("p_mix",    0, nop(),            0, 0, C_RUN, 2'b01, 2'b10, 4, 2);
      // reset pulsed in the middle of a load-use stall
      cyc("r_ldur",   0, ldur(4, 5),       0, 0, C_RUN, 2'b00, 2'b00, 4, 2);
      cyc("r_lu",     0, r_type(6, 4, 7),  0, 0, C_LU,  2'b00, 2'b00, 4, 2);
      cyc("r_pulse",  1, r_type(6, 4, 7),  0, 1, C_RUN, 2'b00, 2'b00, 5, 2);
      cyc("r_post",   0, r_type(6, 4, 7),  0, 0, C_RUN, 2'b00, 2'b00, 0, 0);
      cyc("r_post2",  0, nop(),            0, 0, C_RUN, 2'b00, 2'b00, 0, 0);

      repeat (3) @(posedge clock);
      check("drain", "pending", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
